// File: rtl/truth_table_scanner_pkg.sv
// truth_table_scanner_pkg
// Shared definitions for the truth-table scanner:
//   state_t    - FSM state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3)
//   TT_WIDTH   - truth-table width for the default N_VARS (2^N_VARS)
//   SETTLE_W   - settle-counter width (holds 1..15)
//   tt_width() - 2^n for parameterised instances
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int N_VARS_DEFAULT = 4;
    localparam int TT_WIDTH       = 1 << N_VARS_DEFAULT;
    localparam int SETTLE_W       = 4;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if
// Bundles the scan handshake and the truth-table result bus.
//   start         - request a scan (seen only while the scanner is idle)
//   busy / done   - scan in progress / one-cycle result-valid pulse
//   vec_out       - input vector driven onto the function under test
//   f_in          - function output for the current vec_out
//   table_out     - captured truth table, bit k = f(k)
//   ones_cnt      - number of ones in table_out
// With TRUTH_TABLE_SCANNER_COMPARE_EN defined it also carries
//   expected, mismatch, first_bad_idx.
// Handshake: start is a level; a scan is accepted on the first rising
// edge where start=1 and the scanner is idle. From that edge busy stays
// high until the edge leaving DONE; done is high for exactly the DONE
// cycle, and table_out/ones_cnt are valid from then until the next
// acceptance. There is no backpressure on the result.
// Modports: master = whoever drives start/f_in, slave = the scanner.
interface truth_table_scanner_if #(
    parameter int N_VARS = 4
);
    localparam int TT_W = 1 << N_VARS;

    logic              start;
    logic              busy;
    logic              done;
    logic [N_VARS-1:0] vec_out;
    logic              f_in;
    logic [TT_W-1:0]   table_out;
    logic [N_VARS:0]   ones_cnt;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    logic [TT_W-1:0]   expected;
    logic              mismatch;
    logic [N_VARS-1:0] first_bad_idx;

    modport master (
        output start, f_in, expected,
        input  busy, done, vec_out, table_out, ones_cnt, mismatch, first_bad_idx
    );
    modport slave (
        input  start, f_in, expected,
        output busy, done, vec_out, table_out, ones_cnt, mismatch, first_bad_idx
    );
`else
    modport master (
        output start, f_in,
        input  busy, done, vec_out, table_out, ones_cnt
    );
    modport slave (
        input  start, f_in,
        output busy, done, vec_out, table_out, ones_cnt
    );
`endif
endinterface

// File: rtl/truth_table_scanner_scan_vec_counter.sv
// scan_vec_counter
// Holds the vector being driven and the per-vector settle counter.
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart: vector and settle counter to 0
//   step      - advance to the next vector and restart settling
//   count     - one more settle cycle elapsed
//   vec       - current vector
//   last_vec  - vec is 2^N_VARS-1
//   settled   - the settle counter reaches SETTLE_CYCLES on this edge
module scan_vec_counter
    import truth_table_scanner_pkg::*;
#(
    parameter int N_VARS        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic              count,
    output logic [N_VARS-1:0] vec,
    output logic              last_vec,
    output logic              settled
);
    logic [SETTLE_W-1:0] settle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else if (clear) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else if (step) begin
            vec        <= vec + 1'b1;
            settle_cnt <= '0;
        end else if (count) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    // Looks one count ahead so the FSM leaves DRIVE on the edge where the
    // counter becomes SETTLE_CYCLES.
    assign settled  = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
    assign last_vec = (vec == {N_VARS{1'b1}});
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
// Drives every vector 0..2^N_VARS-1 onto an external combinational
// function, holds each for SETTLE_CYCLES cycles, samples f_in and
// assembles the truth table plus its ones count.
//   clk, rst   - clock, asynchronous active-high reset
//   bus        - truth_table_scanner_if.slave (start/busy/done, vec_out,
//                f_in, table_out, ones_cnt)
//   state_dbg  - current FSM state
// Parameters: N_VARS (2..6), SETTLE_CYCLES (1..15).
// Optional: TRUTH_TABLE_SCANNER_COMPARE_EN adds a compare against the
// expected table latched at acceptance, reporting the first bad minterm.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int N_VARS        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_scanner_if.slave  bus,
    output state_t                state_dbg
);
    localparam int TT_W = tt_width(N_VARS);

    state_t            state;
    logic              busy_q;
    logic              done_q;
    logic [TT_W-1:0]   table_q;
    logic [N_VARS:0]   ones_q;
    logic [N_VARS-1:0] vec;
    logic              last_vec;
    logic              settled;
    logic              accept;

    assign accept = (state == IDLE) && bus.start;

    scan_vec_counter #(
        .N_VARS        (N_VARS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .step     ((state == SAMPLE) && !last_vec),
        .count    (state == DRIVE),
        .vec      (vec),
        .last_vec (last_vec),
        .settled  (settled)
    );

`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    logic [TT_W-1:0]   exp_q;
    logic              mismatch_q;
    logic [N_VARS-1:0] first_bad_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            ones_q  <= '0;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
            exp_q       <= '0;
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state   <= DRIVE;
                        busy_q  <= 1'b1;
                        table_q <= '0;
                        ones_q  <= '0;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
                        exp_q       <= bus.expected;
                        mismatch_q  <= 1'b0;
                        first_bad_q <= '0;
`endif
                    end
                end
                DRIVE: begin
                    if (settled) state <= SAMPLE;
                end
                SAMPLE: begin
                    table_q[vec] <= bus.f_in;
                    ones_q       <= ones_q + {{N_VARS{1'b0}}, bus.f_in};
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
                    // Only the first disagreement is kept.
                    if ((bus.f_in != exp_q[vec]) && !mismatch_q) begin
                        mismatch_q  <= 1'b1;
                        first_bad_q <= vec;
                    end
`endif
                    if (last_vec) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.vec_out   = vec;
    assign bus.table_out = table_q;
    assign bus.ones_cnt  = ones_q;
    assign state_dbg     = state;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    assign bus.mismatch      = mismatch_q;
    assign bus.first_bad_idx = first_bad_q;
`endif
endmodule
